pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Next-PC controller for the MIPS fetch stage. Arbitrates each cycle between
//   sequential fetch, branch redirect, jump redirect, load-use hold, HALT and
//   debug single-step. Drives the PC register's stall/use-npc/jump-address
//   inputs and the IF/ID flush. Sits between hazard unit, ID/EX control and PC.
// PARAMETERS
//   ADDR_W      32  width of PC / target addresses (word-addressed)
//   CNT_W       32  width of retired-fetch counter
//   MAX_HOLD    15  consecutive load-use hold cycles before hold_error sets
// PORTS
//   clock            in   1       system clock
//   reset            in   1       synchronous, active-high
//   load_use_hazard  in   1       hazard unit requests a fetch hold
//   branch_taken     in   1       branch resolved taken this cycle
//   branch_target    in   ADDR_W  branch destination
//   jump_valid       in   1       J/JAL/JR decoded this cycle
//   jump_target      in   ADDR_W  jump destination
//   halt_decoded     in   1       HALT opcode in ID
//   resume_req       in   1       leave HALTED (1-cycle pulse)
//   run_mode         in   1       1 = free run, 0 = single-step
//   step_req         in   1       in step mode: advance one fetch
//   pc_stall         out  1       hold PC this cycle
//   pc_use_npc       out  1       1 = PC+1, 0 = load pc_jump_address
//   pc_jump_address  out  ADDR_W  redirect target
//   flush_if_id      out  1       squash instruction in IF/ID
//   halted           out  1       state == HALTED
//   hold_error       out  1       sticky: hold exceeded MAX_HOLD
//   fetch_count      out  CNT_W   number of advancing cycles since reset
// BEHAVIOUR
//   - States: RUN, STEP_IDLE, STEP_GO, HALTED. Reset -> RUN (RUN_MODE ignored
//     until first post-reset edge). Outputs/state update on rising clock.
//   - Reset values: state RUN, fetch_count 0, hold_error 0, hold counter 0.
//   - Decision (combinational, same cycle) in RUN/STEP_GO, priority high->low:
//     1 halt_decoded: pc_stall=1, flush_if_id=1; next HALTED.
//     2 branch_taken: pc_stall=0, pc_use_npc=0, addr=branch_target, flush=1.
//     3 jump_valid:   pc_stall=0, pc_use_npc=0, addr=jump_target,  flush=1.
//     4 load_use_hazard: pc_stall=1, flush=0 (redirects override the hold).
//     5 else: pc_stall=0, pc_use_npc=1.
//   - pc_jump_address = 0 whenever pc_use_npc=1 or pc_stall=1.
//   - STEP_IDLE and HALTED: pc_stall=1, pc_use_npc=1, flush=0.
//   - RUN: run_mode=0 -> STEP_IDLE next cycle (current cycle still advances).
//   - STEP_IDLE: step_req -> STEP_GO; run_mode=1 -> RUN (run_mode wins).
//   - STEP_GO: one decision cycle; if it advanced -> STEP_IDLE; if held by
//     hazard stay STEP_GO until it advances; halt -> HALTED.
//   - HALTED: resume_req -> RUN if run_mode else STEP_IDLE; other inputs ignored.
//   - fetch_count += 1 (wraps at 2^CNT_W) on every cycle with pc_stall=0.
//   - Hold counter: +1 per cycle where rule 4 wins, saturates; cleared on any
//     non-hold cycle. Reaching MAX_HOLD sets hold_error; cleared only by reset.
//   - reset mid-operation (any state, any input) -> RUN next cycle, all cleared.
// CONFIGURATION
//   PC_SEQ_STEP_EN defined: run_mode/step_req/STEP_* states active as above.
//   Not defined: run_mode, step_req ignored; STEP_IDLE/STEP_GO unreachable;
//     HALTED + resume_req always returns to RUN.
// TESTING
//   1 reset 2 cycles, no requests 5 cycles -> pc_use_npc=1, stall=0, count=5.
//   2 load_use_hazard 1 cycle -> pc_stall=1 that cycle only, count unchanged.
//   3 load_use_hazard + branch_taken, target 0x40 -> stall=0, addr=0x40, flush=1.
//   4 branch 0x40 + jump 0x80 same cycle -> addr=0x40; jump alone -> 0x80.
//   5 halt_decoded -> halted=1 next cycle, stall=1 for 10 cycles; resume_req ->
//     RUN, count resumes; hazard held 15 cycles -> hold_error=1, sticky.
//   6 (STEP_EN) run_mode=0, three step_req pulses spaced 4 cycles -> count +3,
//     stall=1 between steps; reset asserted during STEP_GO -> RUN, count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: picks sequential/branch/jump/hold/halt each cycle.
// Optional debug single-step is enabled by defining PC_SEQ_STEP_EN.
module pc_sequencer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_use_hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_decoded,
    input  logic              resume_req,
    input  logic              run_mode,
    input  logic              step_req,
    output logic              pc_stall,
    output logic              pc_use_npc,
    output logic [ADDR_W-1:0] pc_jump_address,
    output logic              flush_if_id,
    output logic              halted,
    output logic              hold_error,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_STEP_IDLE = 2'd1,
        S_STEP_GO   = 2'd2,
        S_HALTED    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              hold_win;
    logic [HOLD_W-1:0] hold_cnt;

`ifndef PC_SEQ_STEP_EN
    logic unused_step_c;
    assign unused_step_c = run_mode ^ step_req;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (halt_decoded) begin
                    state_next = S_HALTED;
`ifdef PC_SEQ_STEP_EN
                end else if (!run_mode) begin
                    state_next = S_STEP_IDLE;
`endif
                end
            end
            S_STEP_IDLE: begin
`ifdef PC_SEQ_STEP_EN
                if (run_mode) begin
                    state_next = S_RUN;
                end else if (step_req) begin
                    state_next = S_STEP_GO;
                end
`else
                state_next = S_RUN;
`endif
            end
            S_STEP_GO: begin
`ifdef PC_SEQ_STEP_EN
                // A hazard-held step stays armed until it actually advances
                if (halt_decoded) begin
                    state_next = S_HALTED;
                end else if (!pc_stall) begin
                    state_next = S_STEP_IDLE;
                end
`else
                state_next = S_RUN;
`endif
            end
            S_HALTED: begin
                if (resume_req) begin
`ifdef PC_SEQ_STEP_EN
                    state_next = run_mode ? S_RUN : S_STEP_IDLE;
`else
                    state_next = S_RUN;
`endif
                end
            end
            default: state_next = S_RUN;
        endcase
    end

    // Fetch decision; redirects outrank the load-use hold
    always_comb begin
        pc_stall        = 1'b1;
        pc_use_npc      = 1'b1;
        pc_jump_address = '0;
        flush_if_id     = 1'b0;
        hold_win        = 1'b0;
        if (state == S_RUN || state == S_STEP_GO) begin
            if (halt_decoded) begin
                flush_if_id = 1'b1;
            end else if (branch_taken) begin
                pc_stall        = 1'b0;
                pc_use_npc      = 1'b0;
                pc_jump_address = branch_target;
                flush_if_id     = 1'b1;
            end else if (jump_valid) begin
                pc_stall        = 1'b0;
                pc_use_npc      = 1'b0;
                pc_jump_address = jump_target;
                flush_if_id     = 1'b1;
            end else if (load_use_hazard) begin
                hold_win = 1'b1;
            end else begin
                pc_stall = 1'b0;
            end
        end
    end

    assign halted = (state == S_HALTED);

    // Retired-fetch counter and load-use hold watchdog
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
            hold_cnt    <= '0;
            hold_error  <= 1'b0;
        end else begin
            if (!pc_stall) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (hold_win) begin
                if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                if (hold_cnt >= HOLD_W'(MAX_HOLD - 1)) begin
                    hold_error <= 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle reference model plus literal spot checks.
// Step-mode scenarios run only when PC_SEQ_STEP_EN is defined.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 32;
    localparam int          MAX_HOLD = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_use_hazard;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_target;
    logic              halt_decoded;
    logic              resume_req;
    logic              run_mode;
    logic              step_req;
    logic              pc_stall;
    logic              pc_use_npc;
    logic [ADDR_W-1:0] pc_jump_address;
    logic              flush_if_id;
    logic              halted;
    logic              hold_error;
    logic [CNT_W-1:0]  fetch_count;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clock           (clock),
        .reset           (reset),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump_valid      (jump_valid),
        .jump_target     (jump_target),
        .halt_decoded    (halt_decoded),
        .resume_req      (resume_req),
        .run_mode        (run_mode),
        .step_req        (step_req),
        .pc_stall        (pc_stall),
        .pc_use_npc      (pc_use_npc),
        .pc_jump_address (pc_jump_address),
        .flush_if_id     (flush_if_id),
        .halted          (halted),
        .hold_error      (hold_error),
        .fetch_count     (fetch_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode names are the bench's own bookkeeping
    localparam int M_RUN = 0, M_WAIT_STEP = 1, M_STEPPING = 2, M_HALTED = 3;
    int               m_mode  = M_RUN;
    logic [CNT_W-1:0] m_count = '0;
    int               m_hold  = 0;
    bit               m_err   = 1'b0;
    bit               m_valid = 1'b0;
    bit               step_en;

    initial begin
`ifdef PC_SEQ_STEP_EN
        step_en = 1'b1;
`else
        step_en = 1'b0;
`endif
    end

    always @(negedge clock) begin
        bit               deciding, advanced, held_by_hazard;
        bit               e_stall, e_npc, e_flush;
        logic [ADDR_W-1:0] e_addr;
        deciding = (m_mode == M_RUN) || (m_mode == M_STEPPING);
        e_stall = 1'b1; e_npc = 1'b1; e_flush = 1'b0; e_addr = '0;
        held_by_hazard = 1'b0;
        if (deciding) begin
            if (halt_decoded) e_flush = 1'b1;
            else if (branch_taken) begin
                e_stall = 0; e_npc = 0; e_addr = branch_target; e_flush = 1;
            end else if (jump_valid) begin
                e_stall = 0; e_npc = 0; e_addr = jump_target; e_flush = 1;
            end else if (load_use_hazard) held_by_hazard = 1'b1;
            else e_stall = 0;
        end
        advanced = !e_stall;
        if (m_valid) begin
            check("pc_stall", 64'(pc_stall), 64'(e_stall));
            check("pc_use_npc", 64'(pc_use_npc), 64'(e_npc));
            check("pc_jump_address", 64'(pc_jump_address), 64'(e_addr));
            check("flush_if_id", 64'(flush_if_id), 64'(e_flush));
            check("halted", 64'(halted), 64'(m_mode == M_HALTED));
            check("hold_error", 64'(hold_error), 64'(m_err));
            check("fetch_count", 64'(fetch_count), 64'(m_count));
        end
        if (reset) begin
            m_mode = M_RUN; m_count = '0; m_hold = 0; m_err = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (advanced) m_count = m_count + 1;
            if (held_by_hazard) begin
                if (m_hold < MAX_HOLD) m_hold = m_hold + 1;
                if (m_hold >= MAX_HOLD) m_err = 1'b1;
            end else m_hold = 0;
            case (m_mode)
                M_RUN:
                    if (deciding && halt_decoded) m_mode = M_HALTED;
                    else if (step_en && !run_mode) m_mode = M_WAIT_STEP;
                M_WAIT_STEP:
                    if (run_mode) m_mode = M_RUN;
                    else if (step_req) m_mode = M_STEPPING;
                M_STEPPING:
                    if (halt_decoded) m_mode = M_HALTED;
                    else if (advanced) m_mode = M_WAIT_STEP;
                default:
                    if (resume_req) m_mode = (!step_en || run_mode) ? M_RUN : M_WAIT_STEP;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        load_use_hazard = 0; branch_taken = 0; branch_target = '0;
        jump_valid = 0; jump_target = '0; halt_decoded = 0;
        resume_req = 0; run_mode = 1; step_req = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // 1: reset then five free-running fetches
        idle(2);
        reset = 1'b0;
        #1;
        check("lit_reset_count", 64'(fetch_count), 64'd0);
        check("lit_reset_halted", 64'(halted), 64'd0);
        idle(5);
        check("lit_count5", 64'(fetch_count), 64'd5);
        check("lit_seq_npc", 64'(pc_use_npc), 64'd1);
        check("lit_seq_stall", 64'(pc_stall), 64'd0);

        // 2: single load-use hold
        load_use_hazard = 1; #1;
        check("lit_hold_stall", 64'(pc_stall), 64'd1);
        idle(1);
        load_use_hazard = 0; #1;
        check("lit_hold_count", 64'(fetch_count), 64'd5);
        check("lit_hold_released", 64'(pc_stall), 64'd0);

        // 3: branch overrides hold
        load_use_hazard = 1; branch_taken = 1; branch_target = 32'h40; #1;
        check("lit_br_stall", 64'(pc_stall), 64'd0);
        check("lit_br_addr", 64'(pc_jump_address), 64'h40);
        check("lit_br_flush", 64'(flush_if_id), 64'd1);
        idle(1);
        load_use_hazard = 0;

        // 4: branch beats jump; jump alone
        jump_valid = 1; jump_target = 32'h80; #1;
        check("lit_br_over_jmp", 64'(pc_jump_address), 64'h40);
        idle(1);
        branch_taken = 0; #1;
        check("lit_jmp_addr", 64'(pc_jump_address), 64'h80);
        check("lit_jmp_npc", 64'(pc_use_npc), 64'd0);
        idle(1);
        clear_inputs();

        // 5: halt, ignored inputs while halted, resume, hold watchdog
        halt_decoded = 1; #1;
        check("lit_halt_stall", 64'(pc_stall), 64'd1);
        check("lit_halt_flush", 64'(flush_if_id), 64'd1);
        idle(1);
        halt_decoded = 0; branch_taken = 1; branch_target = 32'h123; load_use_hazard = 1; #1;
        check("lit_halted", 64'(halted), 64'd1);
        idle(10);
        check("lit_halted_count", 64'(fetch_count), 64'd8);
        clear_inputs();
        resume_req = 1;
        idle(1);
        resume_req = 0; #1;
        check("lit_resumed", 64'(halted), 64'd0);
        idle(3);
        check("lit_count11", 64'(fetch_count), 64'd11);
        load_use_hazard = 1;
        idle(14);
        check("lit_hold14_noerr", 64'(hold_error), 64'd0);
        idle(1);
        check("lit_hold15_err", 64'(hold_error), 64'd1);
        load_use_hazard = 0;
        idle(3);
        check("lit_err_sticky", 64'(hold_error), 64'd1);
        check("lit_count14", 64'(fetch_count), 64'd14);

`ifdef PC_SEQ_STEP_EN
        // 6: single-step three times, then reset while a step is armed
        run_mode = 0;
        idle(1);
        check("lit_step_entry_count", 64'(fetch_count), 64'd15);
        for (int i = 0; i < 3; i++) begin
            step_req = 1;
            idle(1);
            step_req = 0; #1;
            check("lit_step_go", 64'(pc_stall), 64'd0);
            idle(1);
            check("lit_step_idle", 64'(pc_stall), 64'd1);
            idle(3);
        end
        check("lit_step_count", 64'(fetch_count), 64'd18);
        step_req = 1;
        idle(1);
        step_req = 0;
`endif
        // Reset mid-operation with a hazard pending
        load_use_hazard = 1; reset = 1;
        idle(1);
        reset = 0; load_use_hazard = 0; run_mode = 1; #1;
        check("lit_rst_count", 64'(fetch_count), 64'd0);
        check("lit_rst_err", 64'(hold_error), 64'd0);
        check("lit_rst_run", 64'(pc_stall), 64'd0);
        idle(3);
        check("lit_post_rst_count", 64'(fetch_count), 64'd3);

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
